// File: rtl/game_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// game_pkg : phase encoding, hit sentinel and default PHASE1 masks
// Rev 1.0
// ----------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PHASE1 = 3'd1,
    PHASE2 = 3'd2,
    WIN    = 3'd3,
    LOSE   = 3'd4
  } phase_t;

  localparam int NUM_OBJ_DEF = 10;
  localparam logic [3:0] NO_HIT = 4'd15;

  // Bit 0 of each mask is slot 0 (masks are declared [0:N-1]).
  localparam logic [0:NUM_OBJ_DEF-1] PHASE1_VAC_MASK_DEF = 10'b1111100000;
  localparam logic [0:NUM_OBJ_DEF-1] PHASE1_COR_MASK_DEF = 10'b0000000011;

endpackage
`default_nettype wire

// File: rtl/frame_countdown.sv
`default_nettype none
// ----------------------------------------------------------------------
// frame_countdown : loadable down-counter, decrements on pulse, stops at 0
// Rev 1.0
// ----------------------------------------------------------------------
module frame_countdown #(
  parameter int               WIDTH       = 11,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  // Load wins over decrement so a phase entry on a frame pulse starts full.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= RESET_VALUE;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/game_phase_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------
// game_phase_sequencer : IDLE->PHASE1->PHASE2->WIN/LOSE, score/lives/timer
// and object masks. Optional macro CORONA_RESPAWN_EN enables corona respawn.
// Rev 1.0
// ----------------------------------------------------------------------
module game_phase_sequencer
  import game_pkg::*;
#(
  parameter int                 NUM_OBJ         = NUM_OBJ_DEF,
  parameter logic [0:NUM_OBJ-1] PHASE1_VAC_MASK = PHASE1_VAC_MASK_DEF,
  parameter logic [0:NUM_OBJ-1] PHASE1_COR_MASK = PHASE1_COR_MASK_DEF,
  parameter int                 START_LIVES     = 3,
  parameter int                 SCORE_W         = 8,
  parameter int                 PHASE_FRAMES    = 1800,
  parameter int                 RESPAWN_FRAMES  = 90
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startGame,
  input  logic               hitPulse,
  input  logic [3:0]         hitVacIdx,
  input  logic [3:0]         hitCorIdx,
  output logic [0:NUM_OBJ-1] activeVac,
  output logic [0:NUM_OBJ-1] activeCor,
  output logic [2:0]         phase,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [10:0]        framesLeft,
  output logic               phaseStart
);

  localparam logic [2:0] c_IDLE   = IDLE;
  localparam logic [2:0] c_PHASE1 = PHASE1;
  localparam logic [2:0] c_PHASE2 = PHASE2;
  localparam logic [2:0] c_WIN    = WIN;
  localparam logic [2:0] c_LOSE   = LOSE;
  localparam logic [3:0] c_NUM_IDX = 4'(NUM_OBJ);

  if ((NUM_OBJ > 15) || (PHASE_FRAMES > 2047) || (RESPAWN_FRAMES < 1)
      || (RESPAWN_FRAMES > 2047)) begin : g_cfg_check
    $error("game_phase_sequencer: parameter out of range");
  end

  logic [2:0]         r_state, w_next_state;
  logic [0:NUM_OBJ-1] r_vac, r_cor, w_next_vac, w_next_cor, w_vac_after, w_cor_resp;
  logic [SCORE_W-1:0] r_score, w_next_score, w_score_after;
  logic [1:0]         r_lives, w_next_lives, w_lives_after;
  logic               r_phase_start, w_enter;
  logic               w_in_play, w_tick, w_vac_hit, w_cor_hit, w_frames_zero;
  logic [10:0]        w_frames;

  assign w_in_play = (r_state == c_PHASE1) || (r_state == c_PHASE2);
  assign w_tick    = w_in_play & startOfFrame;
  assign w_vac_hit = w_in_play & hitPulse & (hitVacIdx < c_NUM_IDX) & r_vac[hitVacIdx];
  assign w_cor_hit = w_in_play & hitPulse & (hitCorIdx < c_NUM_IDX) & r_cor[hitCorIdx];

  always_comb begin
    w_vac_after = r_vac;
    if (w_vac_hit) w_vac_after[hitVacIdx] = 1'b0;
  end

  assign w_score_after = (w_vac_hit && (r_score != {SCORE_W{1'b1}}))
                         ? r_score + SCORE_W'(1) : r_score;
  assign w_lives_after = (w_cor_hit && (r_lives != 2'd0)) ? r_lives - 2'd1 : r_lives;

  frame_countdown #(
    .WIDTH       (11),
    .RESET_VALUE (11'(PHASE_FRAMES))
  ) u_timer (
    .clk        (clk),
    .resetN     (resetN),
    .load       (w_enter),
    .load_value (11'(PHASE_FRAMES)),
    .dec        (w_tick),
    .count      (w_frames),
    .zero       (w_frames_zero)
  );

`ifdef CORONA_RESPAWN_EN
  logic [10:0]        w_resp_count;
  logic               w_resp_zero, w_resp_wrap, w_found;
  logic [0:NUM_OBJ-1] w_cor_after, w_cor_free;

  frame_countdown #(
    .WIDTH       (11),
    .RESET_VALUE ('0)
  ) u_respawn (
    .clk        (clk),
    .resetN     (resetN),
    .load       (w_enter | w_resp_wrap),
    .load_value (11'(RESPAWN_FRAMES)),
    .dec        (w_tick),
    .count      (w_resp_count),
    .zero       (w_resp_zero)
  );

  // The frame that takes the count from 1 is the RESPAWN_FRAMES-th one.
  assign w_resp_wrap = w_tick & (w_resp_zero | (w_resp_count == 11'd1));

  always_comb begin
    w_cor_after = r_cor;
    if (w_cor_hit) w_cor_after[hitCorIdx] = 1'b0;
    w_cor_free = ((r_state == c_PHASE1) ? PHASE1_COR_MASK : {NUM_OBJ{1'b1}}) & ~w_cor_after;
    w_cor_resp = w_cor_after;
    w_found    = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (w_resp_wrap && !w_found && w_cor_free[i]) begin
        w_cor_resp[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end
`else
  assign w_cor_resp = r_cor;
`endif

  always_comb begin
    w_next_state = r_state;
    w_enter      = 1'b0;
    w_next_vac   = r_vac;
    w_next_cor   = r_cor;
    w_next_score = r_score;
    w_next_lives = r_lives;
    case (r_state)
      c_PHASE1, c_PHASE2: begin
        w_next_vac   = w_vac_after;
        w_next_cor   = w_cor_resp;
        w_next_score = w_score_after;
        w_next_lives = w_lives_after;
        if (w_lives_after == 2'd0) begin
          w_next_state = c_LOSE;
          w_next_vac   = '0;
          w_next_cor   = '0;
        end else if (w_vac_after == '0) begin
          if (r_state == c_PHASE1) begin
            w_next_state = c_PHASE2;
            w_enter      = 1'b1;
            w_next_vac   = '1;
            w_next_cor   = '1;
          end else begin
            w_next_state = c_WIN;
            w_next_vac   = '0;
            w_next_cor   = '0;
          end
        end else if (w_frames_zero) begin
          w_next_state = c_LOSE;
          w_next_vac   = '0;
          w_next_cor   = '0;
        end
      end
      default: begin
        if (startGame) begin
          w_next_state = c_PHASE1;
          w_enter      = 1'b1;
          w_next_vac   = PHASE1_VAC_MASK;
          w_next_cor   = PHASE1_COR_MASK;
          w_next_score = '0;
          w_next_lives = 2'(START_LIVES);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= c_IDLE;
      r_vac         <= '0;
      r_cor         <= '0;
      r_score       <= '0;
      r_lives       <= 2'(START_LIVES);
      r_phase_start <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_vac         <= w_next_vac;
      r_cor         <= w_next_cor;
      r_score       <= w_next_score;
      r_lives       <= w_next_lives;
      r_phase_start <= w_enter;
    end
  end

  assign activeVac  = r_vac;
  assign activeCor  = r_cor;
  assign phase      = r_state;
  assign score      = r_score;
  assign lives      = r_lives;
  assign framesLeft = w_frames;
  assign phaseStart = r_phase_start;

endmodule
`default_nettype wire
